// File: rtl/gng_noise_ctrl.sv
// Sequencer/flow controller for gng_top: rate-paced clock enable, warm-up discard, drained shift updates, output FIFO.
// Optional statistics counters are built when GNG_NOISE_CTRL_STATS_EN is defined.
module gng_noise_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int WARMUP = 64,
  parameter int RATE_W = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [RATE_W-1:0]        i_rate_div,
  input  logic [3:0]               i_shift_cfg,
  input  logic                     i_shift_load,
  output logic                     o_gng_ce,
  output logic [3:0]               o_gng_shift,
  input  logic signed [DATA_W-1:0] i_gng_data,
  input  logic                     i_gng_valid,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [1:0]               o_state,
  output logic                     o_shift_busy
`ifdef GNG_NOISE_CTRL_STATS_EN
  ,
  output logic [31:0]              o_sample_cnt,
  output logic [31:0]              o_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_WARM = 2'b01, S_RUN = 2'b10, S_STOP = 2'b11} state_t;

  state_t                    r_state, w_next;
  logic [CW-1:0]             r_inflight, r_count;
  logic [AW-1:0]             r_wr_ptr, r_rd_ptr;
  logic signed [DATA_W-1:0]  r_mem [DEPTH];
  logic [WW-1:0]             r_warm_cnt;
  logic [RATE_W-1:0]         r_rate_cnt, r_rate_div;
  logic [3:0]                r_shift_pend, r_gng_shift;
  logic                      r_shift_busy;

  logic w_ret, w_warm_done, w_drop, w_wr, w_rd, w_start, w_apply;
  logic w_credit_run, w_credit_warm, w_drop_only;

  // Returns with nothing outstanding (e.g. stragglers from before a reset) are ignored.
  assign w_ret        = i_gng_valid && (r_inflight != '0);
  assign w_warm_done  = (r_warm_cnt == WW'(WARMUP));
  assign w_drop       = w_ret && !w_warm_done;
  assign w_wr         = w_ret && w_warm_done;
  assign w_rd         = o_valid && i_ready;
  assign w_start      = (r_state == S_IDLE) && (w_next == S_WARM);
  assign w_credit_run = ({1'b0, r_inflight} + {1'b0, r_count}) < (CW+1)'(DEPTH);
  // Samples that will all be discarded need no FIFO slot; later warm-up issues must reserve one.
  assign w_drop_only  = (int'(r_warm_cnt) + int'(r_inflight)) < WARMUP;
  assign w_credit_warm = w_drop_only ? (r_inflight < CW'(DEPTH)) : w_credit_run;
  assign w_apply      = r_shift_busy && (r_inflight == '0) && !o_gng_ce && (r_state != S_WARM);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_enable && (r_inflight == '0)) w_next = S_WARM;
      S_WARM: if (!i_enable) w_next = S_STOP;
              else if (w_warm_done) w_next = S_RUN;
      S_RUN:  if (!i_enable) w_next = S_STOP;
      S_STOP: if (r_inflight == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_gng_ce = 1'b0;
    case (r_state)
      S_WARM:  o_gng_ce = w_credit_warm;
      S_RUN:   o_gng_ce = (r_rate_cnt == '0) && w_credit_run && !r_shift_busy;
      default: o_gng_ce = 1'b0;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_inflight <= '0;
      r_warm_cnt <= '0;
      r_rate_cnt <= '0;
      r_rate_div <= '0;
    end else begin
      if (o_gng_ce && !w_ret)      r_inflight <= r_inflight + CW'(1);
      else if (!o_gng_ce && w_ret) r_inflight <= r_inflight - CW'(1);
      if (w_start)     r_warm_cnt <= '0;
      else if (w_drop) r_warm_cnt <= r_warm_cnt + WW'(1);
      // A period starts at each issued ce; the divider is sampled there and the count holds at 0 while blocked.
      if (w_start) begin
        r_rate_cnt <= '0;
      end else if (r_state == S_RUN) begin
        if (r_rate_cnt == '0) begin
          if (o_gng_ce) begin
            r_rate_div <= i_rate_div;
            r_rate_cnt <= (i_rate_div == '0) ? '0 : RATE_W'(1);
          end
        end else if (r_rate_cnt >= r_rate_div) begin
          r_rate_cnt <= '0;
        end else begin
          r_rate_cnt <= r_rate_cnt + RATE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (w_rd && !w_wr) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_gng_data;
  end

  assign o_valid = (r_count != '0) && (r_state != S_WARM);
  assign o_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_state = r_state;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_shift_pend <= '0;
      r_gng_shift  <= '0;
      r_shift_busy <= 1'b0;
    end else if (i_shift_load) begin
      r_shift_pend <= i_shift_cfg;
      r_shift_busy <= 1'b1;
    end else if (w_apply) begin
      r_gng_shift  <= r_shift_pend;
      r_shift_busy <= 1'b0;
    end
  end

  assign o_gng_shift  = r_gng_shift;
  assign o_shift_busy = r_shift_busy;

`ifdef GNG_NOISE_CTRL_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_sample_cnt <= '0;
      o_stall_cnt  <= '0;
    end else begin
      if (w_rd) o_sample_cnt <= sat_inc(o_sample_cnt);
      if ((r_state == S_RUN) && (r_rate_cnt == '0) && !o_gng_ce) o_stall_cnt <= sat_inc(o_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_gng_noise_ctrl.sv
// Directed bench for gng_noise_ctrl with a fixed-latency gng model and an in-order output scoreboard.
module tb_gng_noise_ctrl;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int WARMUP = 64;
  localparam int RATE_W = 8;
  localparam int LAT    = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              i_enable, i_shift_load, i_ready;
  logic [RATE_W-1:0] i_rate_div;
  logic [3:0]        i_shift_cfg;
  logic              o_gng_ce, o_valid, o_shift_busy;
  logic [3:0]        o_gng_shift;
  logic [DATA_W-1:0] i_gng_data, o_data;
  logic              i_gng_valid;
  logic [1:0]        o_state;

  int total = 0;
  int bad = 0;
  int epoch = 0;
  int seen_epoch = 0;
  int k = 0;
  int ce_total = 0;
  logic [LAT-1:0]    pv = '0;
  logic [DATA_W-1:0] pd [LAT];
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  gng_noise_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WARMUP(WARMUP), .RATE_W(RATE_W)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(i_enable), .i_rate_div(i_rate_div),
    .i_shift_cfg(i_shift_cfg), .i_shift_load(i_shift_load), .o_gng_ce(o_gng_ce),
    .o_gng_shift(o_gng_shift), .i_gng_data(i_gng_data), .i_gng_valid(i_gng_valid),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_state(o_state),
    .o_shift_busy(o_shift_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fixed-latency gng model; each ce gets a unique value, and every one past the warm-up is expected downstream.
  always @(posedge clk) begin : gng_model
    int kk;
    logic [DATA_W-1:0] smp;
    kk = (epoch != seen_epoch) ? 0 : k;
    smp = DATA_W'(epoch * 1000 + kk);
    pv <= {pv[LAT-2:0], o_gng_ce};
    pd[0] <= smp;
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    if (o_gng_ce) begin
      if (kk >= WARMUP) exp_q.push_back(smp);
      kk++;
      ce_total <= ce_total + 1;
    end
    k <= kk;
    seen_epoch <= epoch;
  end

  assign i_gng_valid = pv[LAT-1];
  assign i_gng_data  = pd[LAT-1];

  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) chk("xfer_unexpected", {16'h0, o_data}, 32'hDEAD_BEEF);
      else chk("xfer_data", {16'h0, o_data}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!o_valid && n < budget) begin cyc(); n++; end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int budget, input logic no_ce);
    int n = 0;
    while (o_state != st && n < budget) begin
      if (no_ce) chk({tag, "_ce"}, 32'(o_gng_ce), 32'd0);
      cyc(); n++;
    end
    chk(tag, 32'(o_state), 32'(st));
  endtask

  initial begin
    int cnt, last, cs, n;
    i_enable = 0; i_shift_load = 0; i_ready = 0; i_rate_div = '0; i_shift_cfg = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ce", 32'(o_gng_ce), 0);
    chk("rst_state", 32'(o_state), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_shift", 32'(o_gng_shift), 0);
    chk("rst_busy", 32'(o_shift_busy), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_state", 32'(o_state), 0);

    // Warm-up: first 64 returns are never presented; the scoreboard expects sample 64 first.
    i_rate_div = 0; i_ready = 1; epoch++; i_enable = 1;
    cyc();
    chk("warm_state", 32'(o_state), 1);
    wait_valid("warm_valid_timeout", 1000);
    chk("warm_to_run", 32'(o_state), 2);
    cyc(20);

    // Rate divider 3: exactly one ce in every four cycles.
    i_rate_div = 3;
    cyc(8);
    cnt = 0; last = -1;
    for (int i = 0; i < 400; i++) begin
      if (o_gng_ce) begin
        cnt++;
        if (last >= 0) chk("rate_gap", 32'(i - last), 4);
        last = i;
      end
      cyc();
    end
    chk("rate_ce_count", 32'(cnt), 100);

    // Backpressure: credit bounds issue to the FIFO depth.
    i_rate_div = 0;
    cyc(4);
    i_ready = 0;
    cs = ce_total;
    cyc(50);
    chk("bp_ce_max", 32'((ce_total - cs) <= DEPTH), 1);
    chk("bp_ce_blocked", 32'(o_gng_ce), 0);
    chk("bp_valid", 32'(o_valid), 1);
    i_ready = 1;
    n = 0;
    while (!o_gng_ce && n < 20) begin cyc(); n++; end
    chk("bp_ce_resume", 32'(n < 20), 1);

    // Shift: second load overwrites; applied only once drained.
    cyc(10);
    i_shift_cfg = 3; i_shift_load = 1;
    cyc();
    i_shift_cfg = 5;
    cyc();
    i_shift_load = 0;
    chk("sh_busy", 32'(o_shift_busy), 1);
    n = 0;
    while (o_shift_busy && n < 30) begin
      chk("sh_drain_ce", 32'(o_gng_ce), 0);
      chk("sh_drain_shift", 32'(o_gng_shift), 0);
      cyc(); n++;
    end
    chk("sh_busy_clear", 32'(o_shift_busy), 0);
    chk("sh_applied", 32'(o_gng_shift), 5);
    n = 0;
    while (!o_gng_ce && n < 5) begin cyc(); n++; end
    chk("sh_ce_resume", 32'(n < 5), 1);

    // Stop: no ce, in-flight samples land in the FIFO, then IDLE.
    cyc(3);
    i_enable = 0;
    cyc();
    chk("stop_state", 32'(o_state), 3);
    wait_state("stop_to_idle", 2'b00, 20, 1'b1);
    cyc(10);
    chk("stop_drained", 32'(exp_q.size()), 0);
    chk("stop_valid", 32'(o_valid), 0);

    // Restart repeats the full warm-up.
    epoch++; i_enable = 1;
    cs = ce_total;
    cyc();
    chk("rs_warm_state", 32'(o_state), 1);
    wait_valid("rs_valid_timeout", 1000);
    chk("rs_ce_before_valid", 32'((ce_total - cs) >= WARMUP + 1), 1);
    chk("rs_run", 32'(o_state), 2);

    // Asynchronous reset mid-RUN with FIFO partly full and samples in flight.
    cyc(10);
    i_ready = 0;
    cyc(3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_ce", 32'(o_gng_ce), 0);
    chk("arst_state", 32'(o_state), 0);
    chk("arst_valid", 32'(o_valid), 0);
    chk("arst_data", 32'(o_data), 0);
    chk("arst_shift", 32'(o_gng_shift), 0);
    chk("arst_busy", 32'(o_shift_busy), 0);
    i_enable = 0;
    cyc(2);
    rst_n = 1'b1;
    i_ready = 1;
    cyc(8);
    chk("late_valid_ignored", 32'(o_valid), 0);
    chk("late_state", 32'(o_state), 0);
    epoch++; i_enable = 1;
    cyc();
    chk("post_rst_start", 32'(o_state), 1);
    wait_valid("post_rst_valid_timeout", 1000);
    cyc(20);
    i_enable = 0;
    cyc();
    wait_state("final_idle", 2'b00, 20, 1'b1);
    cyc(10);
    chk("final_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
